// File: rtl/l2_ecc_mon_pkg.sv
// Shared constants and types for the L2 ECC error monitor: register map,
// bit positions and the register-interface request/response structs.
package l2_ecc_mon_pkg;

  localparam int unsigned AddrWidth = 32;

  localparam logic [AddrWidth-1:0] STATUS_OFFS    = 32'h00;
  localparam logic [AddrWidth-1:0] COUNT_OFFS     = 32'h04;
  localparam logic [AddrWidth-1:0] THRESHOLD_OFFS = 32'h08;
  localparam logic [AddrWidth-1:0] CTRL_OFFS      = 32'h0C;
  localparam logic [AddrWidth-1:0] LAST_SRC_OFFS  = 32'h10;

  localparam int unsigned STATUS_PENDING_BIT   = 0;
  localparam int unsigned STATUS_OVERFLOW_BIT  = 1;
  localparam int unsigned CTRL_CLR_PENDING_BIT = 0;
  localparam int unsigned CTRL_CLR_COUNT_BIT   = 1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 valid;
  } ecc_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } ecc_reg_rsp_t;

  // Byte-lane merge of a write into an existing 32-bit register value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_ecc_mon_regs.sv
// Register slave for the ECC monitor: address decode, THRESHOLD storage,
// CTRL pulses and the combinational read/error response.
module l2_ecc_mon_regs
  import l2_ecc_mon_pkg::*;
#(
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned SrcIdxWidth = 1,
  parameter type         reg_req_t   = ecc_reg_req_t,
  parameter type         reg_rsp_t   = ecc_reg_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  reg_req_t               reg_req_i,
  output reg_rsp_t               reg_rsp_o,
  input  logic                   pending_i,
  input  logic                   overflow_i,
  input  logic [CntWidth-1:0]    count_i,
  input  logic [SrcIdxWidth-1:0] last_src_i,
  output logic [CntWidth-1:0]    threshold_o,
  output logic                   clr_pending_o,
  output logic                   clr_count_o
);

  logic [CntWidth-1:0] threshold_q, threshold_d;
  logic [31:0]         thr_merged;

  assign thr_merged  = apply_wstrb(32'(threshold_q), reg_req_i.wdata, reg_req_i.wstrb);
  assign threshold_o = threshold_q;

  always_comb begin : decode
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    threshold_d     = threshold_q;
    clr_pending_o   = 1'b0;
    clr_count_o     = 1'b0;
    if (reg_req_i.valid) begin
      case (reg_req_i.addr)
        STATUS_OFFS: begin
          if (reg_req_i.write) begin
            reg_rsp_o.error = 1'b1;
          end else begin
            reg_rsp_o.rdata[STATUS_PENDING_BIT]  = pending_i;
            reg_rsp_o.rdata[STATUS_OVERFLOW_BIT] = overflow_i;
          end
        end
        COUNT_OFFS: begin
          if (reg_req_i.write) reg_rsp_o.error = 1'b1;
          else                 reg_rsp_o.rdata = 32'(count_i);
        end
        THRESHOLD_OFFS: begin
          if (reg_req_i.write) threshold_d     = thr_merged[CntWidth-1:0];
          else                 reg_rsp_o.rdata = 32'(threshold_q);
        end
        CTRL_OFFS: begin
          // Action bits all live in byte 0; reads return zero.
          if (reg_req_i.write && reg_req_i.wstrb[0]) begin
            clr_pending_o = reg_req_i.wdata[CTRL_CLR_PENDING_BIT];
            clr_count_o   = reg_req_i.wdata[CTRL_CLR_COUNT_BIT];
          end
        end
        LAST_SRC_OFFS: begin
          if (reg_req_i.write) reg_rsp_o.error = 1'b1;
          else                 reg_rsp_o.rdata = 32'(last_src_i);
        end
        default: reg_rsp_o.error = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_ni) threshold_q <= '0;
    else         threshold_q <= threshold_d;
  end

endmodule

// File: rtl/popcount.sv
// Population count with the common_cells port interface (combinational).
module popcount #(
  parameter int unsigned INPUT_WIDTH    = 256,
  parameter int unsigned POPCOUNT_WIDTH = $clog2(INPUT_WIDTH) + 1
) (
  input  logic [INPUT_WIDTH-1:0]    data_i,
  output logic [POPCOUNT_WIDTH-1:0] popcount_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    popcount_o = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      popcount_o = popcount_o + POPCOUNT_WIDTH'(data_i[i]);
    end
  end

endmodule

// File: rtl/l2_ecc_err_monitor.sv
// L2 ECC error event monitor: edge-detects error flags, keeps a saturating
// event count and raises a latched interrupt at a programmable threshold.
module l2_ecc_err_monitor
  import l2_ecc_mon_pkg::*;
#(
  parameter int unsigned NumSrc    = 1,
  parameter int unsigned CntWidth  = 16,
  parameter type         reg_req_t = ecc_reg_req_t,
  parameter type         reg_rsp_t = ecc_reg_rsp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] ecc_error_i,
  input  reg_req_t          reg_req_i,
  output reg_rsp_t          reg_rsp_o,
  output logic              irq_o
);

  localparam int unsigned PopWidth    = $clog2(NumSrc) + 1;
  localparam int unsigned SumWidth    = CntWidth + $clog2(NumSrc + 1);
  localparam int unsigned SrcIdxWidth = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  logic [NumSrc-1:0]      prev_q, events;
  logic                   any_event;
  logic [PopWidth-1:0]    event_cnt;
  logic [SumWidth-1:0]    count_sum;
  logic                   saturate, thr_hit;
  logic [CntWidth-1:0]    count_q, count_d, threshold;
  logic                   overflow_q, overflow_d;
  logic                   pending_q, pending_d;
  logic [SrcIdxWidth-1:0] last_src_q, last_src_d, first_src;
  logic                   clr_pending, clr_count;

  assign events    = ecc_error_i & ~prev_q;
  assign any_event = |events;
  assign irq_o     = pending_q;

  popcount #(
    .INPUT_WIDTH (NumSrc)
  ) i_popcount (
    .data_i     (events),
    .popcount_o (event_cnt)
  );

  // Scan from the top so the lowest-index edge is the one that sticks.
  always_comb begin : first_src_sel
    first_src = '0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (events[i]) first_src = SrcIdxWidth'(i);
    end
  end

  always_comb begin : count_next
    count_sum  = (clr_count ? '0 : SumWidth'(count_q)) + SumWidth'(event_cnt);
    saturate   = count_sum > SumWidth'({CntWidth{1'b1}});
    count_d    = saturate ? '1 : count_sum[CntWidth-1:0];
    overflow_d = (overflow_q & ~clr_count) | saturate;
    // Pending is set by new events only, so software can clear it while the
    // count still sits above the threshold; a same-cycle crossing beats clear.
    thr_hit    = any_event && (threshold != '0) && (count_d >= threshold);
    pending_d  = (pending_q & ~clr_pending) | thr_hit;
    last_src_d = clr_count ? '0 : last_src_q;
    if (any_event) last_src_d = first_src;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
      last_src_q <= '0;
    end else begin
      prev_q     <= ecc_error_i;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      last_src_q <= last_src_d;
    end
  end

  l2_ecc_mon_regs #(
    .CntWidth    (CntWidth),
    .SrcIdxWidth (SrcIdxWidth),
    .reg_req_t   (reg_req_t),
    .reg_rsp_t   (reg_rsp_t)
  ) i_regs (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .reg_req_i     (reg_req_i),
    .reg_rsp_o     (reg_rsp_o),
    .pending_i     (pending_q),
    .overflow_i    (overflow_q),
    .count_i       (count_q),
    .last_src_i    (last_src_q),
    .threshold_o   (threshold),
    .clr_pending_o (clr_pending),
    .clr_count_o   (clr_count)
  );

endmodule
